// File: rtl/mipse_cpu_pkg.sv
// Shared constants and types for the mipse_cpu five-stage MIPS subset core.
package mipse_cpu_pkg;

    localparam int DATA_W = 32;

    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic ENABLE_N  = 1'b0;
    localparam logic DISABLE_N = 1'b1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    // wreg = 0 means "writes nothing"; a bubble is simply CTRL_NOP.
    typedef struct packed {
        logic [4:0] wreg;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        alu_op_e    aluop;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_NOP = '{wreg: 5'd0, memtoreg: DISABLE, memwrite: DISABLE,
                                      alusrc: DISABLE, aluop: ALU_ADD};

endpackage

// File: rtl/mipse_cpu_rfile.sv
// 32 x DATA_W register file: two combinational read ports with write-through, one write port.
module rfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] rf [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we && wa != 5'd0) begin
            rf[wa] <= wd;
        end
    end

    // A WB write in the same cycle is visible to the ID-stage read.
    always_comb begin
        rd1 = rf[ra1];
        rd2 = rf[ra2];
        if (we && wa == ra1) rd1 = wd;
        if (we && wa == ra2) rd2 = wd;
        if (ra1 == 5'd0) rd1 = '0;
        if (ra2 == 5'd0) rd2 = '0;
    end

endmodule

// File: rtl/mipse_cpu.sv
// Five-stage in-order MIPS subset pipeline: forwarding, load-use stall, branches resolved in ID.
module mipse_cpu #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] aluout,
    output logic [DATA_W-1:0] writedata,
    output logic              memwrite
);
    import mipse_cpu_pkg::*;

    logic [DATA_W-1:0] pc_q, pc_d, pc4;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [DATA_W-1:0] ifid_pc4_q, ifid_pc4_d;
    ex_ctrl_t          idex_ctrl_q, idex_ctrl_d, ctrl_id;
    logic [4:0]        idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d;
    logic [DATA_W-1:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d, idex_imm_q, idex_imm_d;
    logic [DATA_W-1:0] exmem_alu_q, exmem_alu_d, exmem_wd_q, exmem_wd_d;
    logic [4:0]        exmem_wreg_q, exmem_wreg_d;
    logic              exmem_memtoreg_q, exmem_memtoreg_d, exmem_memwrite_q, exmem_memwrite_d;
    logic [DATA_W-1:0] memwb_result_q, memwb_result_d;
    logic [4:0]        memwb_wreg_q, memwb_wreg_d;

    logic [5:0]        op_id, fn_id;
    logic [4:0]        rs_id, rt_id, rd_id, shamt_id;
    logic [DATA_W-1:0] imm_id, rd1_id, rd2_id, br_a, br_b, br_target, j_target;
    logic              is_beq, is_j, use_rs, use_rt, lw_stall, br_stall, stall, take_br, take_j;
    logic [DATA_W-1:0] fwd_a, fwd_b, src_b, alu_res;

    assign op_id    = ifid_instr_q[31:26];
    assign rs_id    = ifid_instr_q[25:21];
    assign rt_id    = ifid_instr_q[20:16];
    assign rd_id    = ifid_instr_q[15:11];
    assign shamt_id = ifid_instr_q[10:6];
    assign fn_id    = ifid_instr_q[5:0];
    assign imm_id   = {{(DATA_W-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};

    rfile #(.DATA_W(DATA_W)) rfile_1 (
        .clk (clk),
        .rst (rst_n),
        .ra1 (rs_id),
        .ra2 (rt_id),
        .rd1 (rd1_id),
        .rd2 (rd2_id),
        .we  (memwb_wreg_q != 5'd0),
        .wa  (memwb_wreg_q),
        .wd  (memwb_result_q)
    );

    always_comb begin
        ctrl_id = CTRL_NOP;
        is_beq  = DISABLE;
        is_j    = DISABLE;
        use_rs  = DISABLE;
        use_rt  = DISABLE;
        case (op_id)
            OP_RTYPE: begin
                if (shamt_id == 5'd0 && (fn_id == FN_ADD || fn_id == FN_SUB || fn_id == FN_AND ||
                                         fn_id == FN_OR || fn_id == FN_SLT)) begin
                    ctrl_id.wreg = rd_id;
                    use_rs       = ENABLE;
                    use_rt       = ENABLE;
                    case (fn_id)
                        FN_SUB:  ctrl_id.aluop = ALU_SUB;
                        FN_AND:  ctrl_id.aluop = ALU_AND;
                        FN_OR:   ctrl_id.aluop = ALU_OR;
                        FN_SLT:  ctrl_id.aluop = ALU_SLT;
                        default: ctrl_id.aluop = ALU_ADD;
                    endcase
                end
            end
            OP_ADDI: begin
                ctrl_id.wreg   = rt_id;
                ctrl_id.alusrc = ENABLE;
                use_rs         = ENABLE;
            end
            OP_LW: begin
                ctrl_id.wreg     = rt_id;
                ctrl_id.alusrc   = ENABLE;
                ctrl_id.memtoreg = ENABLE;
                use_rs           = ENABLE;
            end
            OP_SW: begin
                ctrl_id.alusrc   = ENABLE;
                ctrl_id.memwrite = ENABLE;
                use_rs           = ENABLE;
                use_rt           = ENABLE;
            end
            OP_BEQ: begin
                is_beq = ENABLE;
                use_rs = ENABLE;
                use_rt = ENABLE;
            end
            OP_J:    is_j = ENABLE;
            default: ;
        endcase
    end

    // beq waits for an ALU producer to reach MEM and for a load producer to reach WB.
    assign lw_stall = idex_ctrl_q.memtoreg && idex_ctrl_q.wreg != 5'd0 &&
                      ((use_rs && rs_id == idex_ctrl_q.wreg) || (use_rt && rt_id == idex_ctrl_q.wreg));
    assign br_stall = is_beq &&
                      ((idex_ctrl_q.wreg != 5'd0 && (rs_id == idex_ctrl_q.wreg || rt_id == idex_ctrl_q.wreg)) ||
                       (exmem_memtoreg_q && exmem_wreg_q != 5'd0 &&
                        (rs_id == exmem_wreg_q || rt_id == exmem_wreg_q)));
    assign stall    = lw_stall || br_stall;

    assign br_a      = (rs_id != 5'd0 && rs_id == exmem_wreg_q) ? exmem_alu_q : rd1_id;
    assign br_b      = (rt_id != 5'd0 && rt_id == exmem_wreg_q) ? exmem_alu_q : rd2_id;
    assign take_br   = is_beq && !stall && (br_a == br_b);
    assign take_j    = is_j && !stall;
    assign pc4       = pc_q + DATA_W'(4);
    assign br_target = ifid_pc4_q + {imm_id[DATA_W-3:0], 2'b00};
    assign j_target  = {ifid_pc4_q[DATA_W-1:28], ifid_instr_q[25:0], 2'b00};

    assign fwd_a = (idex_rs_q != 5'd0 && idex_rs_q == exmem_wreg_q) ? exmem_alu_q :
                   (idex_rs_q != 5'd0 && idex_rs_q == memwb_wreg_q) ? memwb_result_q : idex_a_q;
    assign fwd_b = (idex_rt_q != 5'd0 && idex_rt_q == exmem_wreg_q) ? exmem_alu_q :
                   (idex_rt_q != 5'd0 && idex_rt_q == memwb_wreg_q) ? memwb_result_q : idex_b_q;
    assign src_b = idex_ctrl_q.alusrc ? idex_imm_q : fwd_b;

    always_comb begin
        case (idex_ctrl_q.aluop)
            ALU_SUB: alu_res = fwd_a - src_b;
            ALU_AND: alu_res = fwd_a & src_b;
            ALU_OR:  alu_res = fwd_a | src_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, $signed(fwd_a) < $signed(src_b)};
            default: alu_res = fwd_a + src_b;
        endcase
    end

    always_comb begin
        pc_d         = pc4;
        ifid_instr_d = instr;
        ifid_pc4_d   = pc4;
        idex_ctrl_d  = ctrl_id;
        idex_rs_d    = rs_id;
        idex_rt_d    = rt_id;
        idex_a_d     = rd1_id;
        idex_b_d     = rd2_id;
        idex_imm_d   = imm_id;
        if (stall) begin
            pc_d         = pc_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc4_d   = ifid_pc4_q;
            idex_ctrl_d  = CTRL_NOP;
        end else if (take_br) begin
            pc_d         = br_target;
            ifid_instr_d = '0;
        end else if (take_j) begin
            pc_d         = j_target;
            ifid_instr_d = '0;
        end
        exmem_alu_d      = alu_res;
        exmem_wd_d       = fwd_b;
        exmem_wreg_d     = idex_ctrl_q.wreg;
        exmem_memtoreg_d = idex_ctrl_q.memtoreg;
        exmem_memwrite_d = idex_ctrl_q.memwrite;
        memwb_result_d   = exmem_memtoreg_q ? readdata : exmem_alu_q;
        memwb_wreg_d     = exmem_wreg_q;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc_q             <= '0;
            ifid_instr_q     <= '0;
            ifid_pc4_q       <= '0;
            idex_ctrl_q      <= CTRL_NOP;
            idex_rs_q        <= '0;
            idex_rt_q        <= '0;
            idex_a_q         <= '0;
            idex_b_q         <= '0;
            idex_imm_q       <= '0;
            exmem_alu_q      <= '0;
            exmem_wd_q       <= '0;
            exmem_wreg_q     <= '0;
            exmem_memtoreg_q <= DISABLE;
            exmem_memwrite_q <= DISABLE;
            memwb_result_q   <= '0;
            memwb_wreg_q     <= '0;
        end else begin
            pc_q             <= pc_d;
            ifid_instr_q     <= ifid_instr_d;
            ifid_pc4_q       <= ifid_pc4_d;
            idex_ctrl_q      <= idex_ctrl_d;
            idex_rs_q        <= idex_rs_d;
            idex_rt_q        <= idex_rt_d;
            idex_a_q         <= idex_a_d;
            idex_b_q         <= idex_b_d;
            idex_imm_q       <= idex_imm_d;
            exmem_alu_q      <= exmem_alu_d;
            exmem_wd_q       <= exmem_wd_d;
            exmem_wreg_q     <= exmem_wreg_d;
            exmem_memtoreg_q <= exmem_memtoreg_d;
            exmem_memwrite_q <= exmem_memwrite_d;
            memwb_result_q   <= memwb_result_d;
            memwb_wreg_q     <= memwb_wreg_d;
        end
    end

    assign pc        = pc_q;
    assign aluout    = exmem_alu_q;
    assign writedata = exmem_wd_q;
    assign memwrite  = exmem_memwrite_q;

endmodule

// File: tb/tb_mipse_cpu.sv
// Directed-program bench for mipse_cpu with behavioural imem/dmem and a sw-to-0x7FFF end marker.
module tb_mipse_cpu;
    import mipse_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr, readdata, pc, aluout, writedata;
    logic        memwrite;

    logic [31:0] imem [0:65535];
    logic [31:0] dmem [0:65535];
    logic [31:0] prog [$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int stall_cnt = 0;
    int wr_cnt   = 0;
    int wr_before;

    always #5 clk = ~clk;

    mipse_cpu #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .readdata  (readdata),
        .pc        (pc),
        .aluout    (aluout),
        .writedata (writedata),
        .memwrite  (memwrite)
    );

    assign instr    = imem[pc[17:2]];
    assign readdata = dmem[aluout[17:2]];

    always @(posedge clk) begin
        if (memwrite) begin
            dmem[aluout[17:2]] <= writedata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            cyc_cnt   <= 0;
            stall_cnt <= 0;
        end else begin
            cyc_cnt <= cyc_cnt + 1;
            if (dut.stall) stall_cnt <= stall_cnt + 1;
        end
    end

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] idx);
        return {OP_J, idx};
    endfunction

    function automatic int rf_nonzero();
        int n = 0;
        for (int i = 0; i < 32; i++) if (dut.rfile_1.rf[i] !== 32'd0) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
    endtask

    task automatic run_to_end(input string tag, input bit dump);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (memwrite === 1'b1 && aluout === 32'h0000_7FFF) seen = 1'b1;
        end
        n_assert++;
        assert (seen) else begin
            n_fail++;
            $error("FAIL %s_end: end marker observed %0d expected 1 within 300 cycles", tag, seen);
        end
        if (dump) begin
            for (int k = 100; k < 200; k++) $display("dmem[%0d] = 0x%08h", k, dmem[k]);
        end
        $display("%s: cycles=%0d stalls=%0d", tag, cyc_cnt, stall_cnt);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;

        // Program 1: forwarding chain, store, load-use.
        prog = '{enc_i(OP_ADDI, 5'd1, 5'd0, 16'd5),
                 enc_i(OP_ADDI, 5'd2, 5'd0, 16'd7),
                 enc_r(FN_ADD, 5'd3, 5'd1, 5'd2),
                 enc_i(OP_SW, 5'd3, 5'd0, 16'd0),
                 enc_i(OP_LW, 5'd4, 5'd0, 16'd0),
                 enc_r(FN_ADD, 5'd5, 5'd4, 5'd4),
                 enc_i(OP_ADDI, 5'd31, 5'd0, 16'h7FFF),
                 enc_i(OP_SW, 5'd0, 5'd31, 16'd0)};
        load_prog();
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'd0);
        check("rst_memwrite", {31'd0, memwrite}, 32'd0);
        check("rst_aluout", aluout, 32'd0);
        check("rst_writedata", writedata, 32'd0);
        check("rst_stall", {31'd0, dut.stall}, 32'd0);
        check("rst_rf_nonzero", rf_nonzero(), 32'd0);
        rst_n = 1'b0;
        repeat (6) @(negedge clk);
        check("p1_sw_memwrite", {31'd0, memwrite}, 32'd1);
        check("p1_sw_addr", aluout, 32'd0);
        check("p1_sw_data", writedata, 32'h0000_000C);
        check("p1_sw_pc", pc, 32'd24);
        run_to_end("p1", 1'b0);
        check("p1_rf3", dut.rfile_1.rf[3], 32'h0000_000C);
        check("p1_rf4", dut.rfile_1.rf[4], 32'h0000_000C);
        check("p1_rf5", dut.rfile_1.rf[5], 32'h0000_0018);
        check("p1_mem0", dmem[0], 32'h0000_000C);
        check("p1_stalls", stall_cnt, 32'd1);

        // Program 2: taken beq with an ALU producer in EX squashes the next fetch.
        rst_n = 1'b1;
        prog = '{enc_i(OP_ADDI, 5'd1, 5'd0, 16'd1),
                 enc_i(OP_BEQ, 5'd1, 5'd1, 16'd1),
                 enc_i(OP_ADDI, 5'd6, 5'd0, 16'd9),
                 enc_i(OP_ADDI, 5'd7, 5'd0, 16'd3),
                 enc_i(OP_ADDI, 5'd31, 5'd0, 16'h7FFF),
                 enc_i(OP_SW, 5'd0, 5'd31, 16'd0)};
        load_prog();
        repeat (2) @(negedge clk);
        check("p2_rst_pc", pc, 32'd0);
        check("p2_rst_rf_nonzero", rf_nonzero(), 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("p2_beq_stall", {31'd0, dut.stall}, 32'd1);
        repeat (2) @(negedge clk);
        check("p2_branch_pc", pc, 32'd12);
        run_to_end("p2", 1'b0);
        check("p2_rf1", dut.rfile_1.rf[1], 32'd1);
        check("p2_rf6", dut.rfile_1.rf[6], 32'd0);
        check("p2_rf7", dut.rfile_1.rf[7], 32'd3);
        check("p2_stalls", stall_cnt, 32'd1);

        // Program 3: signed slt/sub, beq after lw, jump, undefined encodings, $0 writes.
        rst_n = 1'b1;
        prog = '{enc_i(OP_ADDI, 5'd1, 5'd0, 16'hFFFF),
                 enc_i(OP_ADDI, 5'd2, 5'd0, 16'd1),
                 enc_r(FN_SLT, 5'd3, 5'd1, 5'd2),
                 enc_r(FN_SUB, 5'd4, 5'd2, 5'd1),
                 enc_i(OP_SW, 5'd4, 5'd0, 16'd4),
                 enc_i(OP_LW, 5'd8, 5'd0, 16'd4),
                 enc_i(OP_BEQ, 5'd4, 5'd8, 16'd1),
                 enc_i(OP_ADDI, 5'd9, 5'd0, 16'd1),
                 enc_j(26'd10),
                 enc_i(OP_ADDI, 5'd10, 5'd0, 16'd1),
                 32'hFC21_0005,
                 enc_r(FN_AND, 5'd11, 5'd1, 5'd2),
                 enc_r(FN_OR, 5'd12, 5'd4, 5'd2),
                 enc_i(OP_ADDI, 5'd0, 5'd0, 16'd5),
                 enc_r(FN_ADD, 5'd13, 5'd0, 5'd0),
                 enc_i(OP_SW, 5'd12, 5'd0, 16'd400),
                 enc_r(6'h21, 5'd14, 5'd1, 5'd2),
                 enc_i(OP_ADDI, 5'd31, 5'd0, 16'h7FFF),
                 enc_i(OP_SW, 5'd0, 5'd31, 16'd0)};
        load_prog();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        run_to_end("p3", 1'b1);
        check("p3_rf1", dut.rfile_1.rf[1], 32'hFFFF_FFFF);
        check("p3_slt", dut.rfile_1.rf[3], 32'd1);
        check("p3_sub", dut.rfile_1.rf[4], 32'd2);
        check("p3_lw", dut.rfile_1.rf[8], 32'd2);
        check("p3_beq_squash", dut.rfile_1.rf[9], 32'd0);
        check("p3_j_squash", dut.rfile_1.rf[10], 32'd0);
        check("p3_and", dut.rfile_1.rf[11], 32'd1);
        check("p3_or", dut.rfile_1.rf[12], 32'd3);
        check("p3_r0_discard", dut.rfile_1.rf[13], 32'd0);
        check("p3_bad_funct", dut.rfile_1.rf[14], 32'd0);
        check("p3_mem1", dmem[1], 32'd2);
        check("p3_mem100", dmem[100], 32'd3);
        check("p3_stalls", stall_cnt, 32'd2);

        // Program 1 again with reset pulsed while its sw sits in MEM.
        rst_n = 1'b1;
        prog = '{enc_i(OP_ADDI, 5'd1, 5'd0, 16'd5),
                 enc_i(OP_ADDI, 5'd2, 5'd0, 16'd7),
                 enc_r(FN_ADD, 5'd3, 5'd1, 5'd2),
                 enc_i(OP_SW, 5'd3, 5'd0, 16'd0),
                 enc_i(OP_LW, 5'd4, 5'd0, 16'd0),
                 enc_r(FN_ADD, 5'd5, 5'd4, 5'd4),
                 enc_i(OP_ADDI, 5'd31, 5'd0, 16'h7FFF),
                 enc_i(OP_SW, 5'd0, 5'd31, 16'd0)};
        load_prog();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (6) @(negedge clk);
        check("p4_pre_memwrite", {31'd0, memwrite}, 32'd1);
        check("p4_pre_rf1", dut.rfile_1.rf[1], 32'd5);
        wr_before = wr_cnt;
        rst_n = 1'b1;
        #1;
        check("p4_rst_pc", pc, 32'd0);
        check("p4_rst_memwrite", {31'd0, memwrite}, 32'd0);
        @(negedge clk);
        check("p4_rst_rf_nonzero", rf_nonzero(), 32'd0);
        check("p4_rst_no_write", wr_cnt, wr_before);
        check("p4_rst_stall", {31'd0, dut.stall}, 32'd0);
        rst_n = 1'b0;
        run_to_end("p4", 1'b0);
        check("p4_rf5", dut.rfile_1.rf[5], 32'h0000_0018);
        check("p4_stalls", stall_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mipse_cpu.md
MIPSE_CPU -- requirements
Module: mipse_cpu

Interface
REQ-001 Parameter DATA_W SHALL default to 32 and set the width of all data and address ports.
REQ-002 clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 rst_n, input, 1, asynchronous reset, active-high (asserted = 1) despite the legacy name.
REQ-004 instr, input, 32, instruction word fetched from external imem at address pc.
REQ-005 readdata, input, 32, word returned combinationally by external dmem for address aluout.
REQ-006 pc, output, 32, fetch address of the IF stage (byte address, word-aligned).
REQ-007 aluout, output, 32, EX/MEM ALU result; this is the data memory byte address in MEM.
REQ-008 writedata, output, 32, EX/MEM store data (forwarded rt value).
REQ-009 memwrite, output, 1, high for exactly the MEM cycle of a valid sw.

Function
REQ-010 The core SHALL be a 5-stage in-order pipeline: IF, ID, EX, MEM, WB.
REQ-011 Supported instructions: R-type add, sub, and, or, slt (funct 0x20, 0x22, 0x24, 0x25, 0x2A); addi (0x08); lw (0x23); sw (0x2B); beq (0x04); j (0x02).
REQ-012 The all-zero word SHALL execute as nop; every other undefined opcode or funct SHALL also execute as nop.
REQ-013 Arithmetic SHALL be 32-bit two's complement, overflow ignored; slt SHALL use a signed compare; immediates SHALL be sign-extended.
REQ-014 Register 0 SHALL read as 0, and writes to it SHALL be discarded.
REQ-015 Register reads in ID SHALL see a same-cycle WB write (write-through bypass).
REQ-016 EX operands SHALL be forwarded from EX/MEM (ALU result) and MEM/WB (ALU or load result); EX/MEM SHALL have priority.
REQ-017 A load-use hazard (lw in EX whose rt equals ID rs or rt) SHALL stall IF/ID for 1 cycle and insert a bubble into EX.
REQ-018 beq and j SHALL resolve in ID; a taken branch or jump SHALL squash the instruction in IF (1-cycle penalty) and there SHALL be no delay slot.
REQ-019 A beq whose operand is produced by an ALU instruction in EX SHALL stall 1 cycle.
REQ-020 A beq whose operand is produced by a lw in EX SHALL stall 2 cycles.
REQ-021 Branch target SHALL be PC+4+(sext(imm)<<2); jump target SHALL be {PC+4[31:28], idx, 2'b00}.
REQ-022 Internal signal stall SHALL be 1 in every cycle that pc and IF/ID are held.
REQ-023 pc SHALL advance by 4 each non-stalled cycle.
REQ-024 Data memory address bits [17:2] SHALL select the word; the core SHALL emit aluout unmodified.
REQ-025 imem (16-bit word index a, 32-bit rd) SHALL read combinationally.
REQ-026 dmem (clk, a, wd, we, rd) SHALL read combinationally and write on the rising clk edge when we = 1.

Reset
REQ-027 While rst_n = 1: pc = 0, all pipeline registers hold nop, memwrite = 0, aluout = 0, writedata = 0, stall = 0, and all 32 registers = 0.
REQ-028 Reset asserted mid-operation SHALL abort all in-flight instructions with no memory write.
REQ-029 The first fetch SHALL be from address 0 on the first rising edge after release.

Structure
REQ-030 A shared package SHALL hold DATA_W, the opcode and funct constants, the ALU-operation encoding, and the ENABLE/DISABLE/ENABLE_N/DISABLE_N constants.
REQ-031 The register file SHALL be sub-module rfile, instanced as rfile_1, with array rf[0:31] of 32 bits, 2 read ports and 1 write port.

Verification
REQ-032 Program "addi $1,$0,5; addi $2,$0,7; add $3,$1,$2" -> rf[3] = 0x0000000C, with no stall cycles (forwarding).
REQ-033 Program "sw $3,0($0)" after the above, then "lw $4,0($0); add $5,$4,$4" -> mem[0] = 0x0C, rf[5] = 0x18, and exactly 1 stall cycle.
REQ-034 Program "addi $1,$0,1; beq $1,$1,+1; addi $6,$0,9; addi $7,$0,3" -> rf[6] = 0, rf[7] = 3, and the squashed instruction has no effect.
REQ-035 Program "slt $3,$1,$2" with $1 = -1, $2 = 1 -> rf[3] = 1; "sub $4,$2,$1" -> rf[4] = 2.
REQ-036 Assert rst_n for 1 cycle mid-program -> pc = 0, memwrite = 0, and rf is all zero.
REQ-037 The end-of-test convention SHALL be: a sw with aluout = 0x00007FFF and memwrite = 1 -> the bench halts and dumps dmem words 100-199 plus the cycle and stall counts.
